accum_sequencer: RTL and testbench



---
 rtl/accum_sequencer.sv | 160 ++++++++++++++++
 tb/tb_accum_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
//
// Counter-controlled accumulator with a start/done handshake.
//
// Operation: a start pulse loads a cycle count. The block then adds or
// subtracts the live data_in once per clock until the count reaches zero.
// It reports busy, done and a sticky overflow/underflow flag.
//
// Parameters:
//   DATA_W : width of data_in. This is an unsigned addend/subtrahend.
//   CNT_W  : width of count_in and count_out. The longest run is
//            2^CNT_W-1 cycles.
//   SUM_W  : width of the accumulator. It must be >= DATA_W.
//
// Ports:
//   CLOCK     in   system clock; all state updates on the rising edge
//   RESETn    in   synchronous, active-low reset; overrides every other input
//   start     in   begins a run; sampled only in IDLE or DONE
//   mode      in   0 = add, 1 = subtract; latched at start
//   count_in  in   number of accumulate cycles; latched at start
//   data_in   in   operand; sampled live on every RUN cycle
//   sum       out  accumulator value (unsigned)
//   count_out out  cycles remaining in the current run
//   busy      out  high while in RUN
//   done      out  high while in DONE
//   ovf       out  sticky overflow/borrow flag for the current run
//
// Build option:
//   ACCUM_SATURATE_EN : when defined, an overflowing add clamps sum to
//                       2^SUM_W-1 and a borrowing subtract clamps sum to 0.
//                       When undefined, sum wraps modulo 2^SUM_W.
// -----------------------------------------------------------------------------
module accum_sequencer #(
   parameter int DATA_W = 5,
   parameter int CNT_W  = 5,
   parameter int SUM_W  = 10
) (
   input  logic              CLOCK,
   input  logic              RESETn,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  count_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [SUM_W-1:0]  sum,
   output logic [CNT_W-1:0]  count_out,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   logic   mode_q;

   // One extra bit is kept above the accumulator. For an add, this bit is
   // the carry out. For a subtract, it is the borrow: the magnitude of data_in
   // never exceeds 2^SUM_W-1, so bit SUM_W is set exactly when the true
   // result is negative.
   function automatic logic [SUM_W:0] acc_raw(
      input logic [SUM_W-1:0]  acc,
      input logic [DATA_W-1:0] d,
      input logic              sub
   );
      logic [SUM_W:0] a_ext;
      logic [SUM_W:0] d_ext;
      a_ext = {1'b0, acc};
      d_ext = '0;
      d_ext[DATA_W-1:0] = d;
      return sub ? (a_ext - d_ext) : (a_ext + d_ext);
   endfunction

`ifdef ACCUM_SATURATE_EN
   // Clamp to the rail that the operation ran past.
   function automatic logic [SUM_W-1:0] acc_sat(
      input logic [SUM_W:0] raw,
      input logic           sub
   );
      if (raw[SUM_W]) begin
         return sub ? '0 : '1;
      end
      return raw[SUM_W-1:0];
   endfunction
`endif

   logic [SUM_W:0]   raw_p0;
   logic [SUM_W-1:0] sum_nxt_p0;
   logic             ovf_hit_p0;

   // ---- combinational next-accumulator stage ----
   always_comb begin
      raw_p0     = acc_raw(sum, data_in, mode_q);
      ovf_hit_p0 = raw_p0[SUM_W];
`ifdef ACCUM_SATURATE_EN
      sum_nxt_p0 = acc_sat(raw_p0, mode_q);
`else
      sum_nxt_p0 = raw_p0[SUM_W-1:0];
`endif
   end

   // ---- registered control and accumulator stage ----
   always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
         state     <= S_IDLE;
         sum       <= '0;
         count_out <= '0;
         mode_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a restart exactly like IDLE does.
            S_IDLE, S_DONE: begin
               if (start) begin
                  count_out <= count_in;
                  sum       <= '0;
                  ovf       <= 1'b0;
                  mode_q    <= mode;
                  if (count_in != '0) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     // A zero-length run goes straight to DONE with sum=0.
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               sum       <= sum_nxt_p0;
               count_out <= count_out - CNT_W'(1);
               if (ovf_hit_p0) begin
                  ovf <= 1'b1;
               end
               if (count_out == CNT_W'(1)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_sequencer.sv
module tb_accum_sequencer;

   localparam int DATA_W = 5;
   localparam int CNT_W  = 5;

`ifdef ACCUM_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              CLOCK = 1'b0;
   logic              RESETn;
   logic              start, start8, mode;
   logic [CNT_W-1:0]  count_in;
   logic [DATA_W-1:0] data_in;

   logic [9:0]        sum10;
   logic [CNT_W-1:0]  cnt10;
   logic              busy10, done10, ovf10;
   logic [7:0]        sum8;
   logic [CNT_W-1:0]  cnt8;
   logic              busy8, done8, ovf8;

   always #5 CLOCK = ~CLOCK;

   accum_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(10)) dut (
      .CLOCK(CLOCK), .RESETn(RESETn), .start(start), .mode(mode),
      .count_in(count_in), .data_in(data_in),
      .sum(sum10), .count_out(cnt10), .busy(busy10), .done(done10), .ovf(ovf10)
   );

   accum_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(8)) dut8 (
      .CLOCK(CLOCK), .RESETn(RESETn), .start(start8), .mode(mode),
      .count_in(count_in), .data_in(data_in),
      .sum(sum8), .count_out(cnt8), .busy(busy8), .done(done8), .ovf(ovf8)
   );

   typedef struct {
      int sum;
      int ovf;
      int cnt;
      int busy;
   } exp_t;

   exp_t q10[$];
   exp_t q8[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor for the SUM_W=10 instance.
   int   bc10 = 0;
   bit   dp10 = 1'b0;
   exp_t e10;
   always @(negedge CLOCK) begin
      if (!RESETn) begin
         bc10 = 0;
         dp10 = 1'b0;
      end else begin
         if (busy10) bc10++;
         if (done10 && !dp10) begin
            if (q10.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done10_unexpected: done rose with sum=%0d and no expected entry", sum10);
            end else begin
               e10 = q10.pop_front();
               chk("w10_sum", int'(sum10), e10.sum);
               chk("w10_ovf", int'(ovf10), e10.ovf);
               chk("w10_count_out", int'(cnt10), e10.cnt);
               chk("w10_busy_cycles", bc10, e10.busy);
            end
            bc10 = 0;
         end
         dp10 = done10;
      end
   end

   // Scoreboard monitor for the SUM_W=8 instance.
   int   bc8 = 0;
   bit   dp8 = 1'b0;
   exp_t e8;
   always @(negedge CLOCK) begin
      if (!RESETn) begin
         bc8 = 0;
         dp8 = 1'b0;
      end else begin
         if (busy8) bc8++;
         if (done8 && !dp8) begin
            if (q8.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done8_unexpected: done rose with sum=%0d and no expected entry", sum8);
            end else begin
               e8 = q8.pop_front();
               chk("w8_sum", int'(sum8), e8.sum);
               chk("w8_ovf", int'(ovf8), e8.ovf);
               chk("w8_count_out", int'(cnt8), e8.cnt);
               chk("w8_busy_cycles", bc8, e8.busy);
            end
            bc8 = 0;
         end
         dp8 = done8;
      end
   end

   task automatic drain(input string nm);
      for (int i = 0; i < 100 && (q10.size() != 0 || q8.size() != 0); i++) begin
         @(negedge CLOCK);
         #1;
      end
      if (q10.size() != 0 || q8.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: pending w10=%0d w8=%0d expected 0", nm, q10.size(), q8.size());
         q10.delete();
         q8.delete();
      end
   endtask

   // Issue one run. The expected completion is queued before the start pulse.
   // The state directly after the start edge is also checked.
   task automatic go(input string nm, input int n, input int d, input bit m,
                     input int es, input int eo,
                     input bit also8, input int es8, input int eo8);
      q10.push_back('{sum: es, ovf: eo, cnt: 0, busy: n});
      if (also8) q8.push_back('{sum: es8, ovf: eo8, cnt: 0, busy: n});
      count_in = CNT_W'(n);
      data_in  = DATA_W'(d);
      mode     = m;
      start    = 1'b1;
      start8   = also8;
      @(posedge CLOCK);
      #1;
      start  = 1'b0;
      start8 = 1'b0;
      @(negedge CLOCK);
      chk({nm, "_start_busy"}, int'(busy10), int'(n != 0));
      chk({nm, "_start_done"}, int'(done10), int'(n == 0));
      chk({nm, "_start_sum"}, int'(sum10), 0);
      chk({nm, "_start_ovf"}, int'(ovf10), 0);
      chk({nm, "_start_cnt"}, int'(cnt10), n);
      drain(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RESETn   = 1'b0;
      start    = 1'b0;
      start8   = 1'b0;
      mode     = 1'b0;
      count_in = '0;
      data_in  = '0;

      // Reset held for two edges.
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      chk("rst_sum", int'(sum10), 0);
      chk("rst_count_out", int'(cnt10), 0);
      chk("rst_busy", int'(busy10), 0);
      chk("rst_done", int'(done10), 0);
      chk("rst_ovf", int'(ovf10), 0);
      chk("rst_sum8", int'(sum8), 0);
      @(posedge CLOCK);
      #1;
      RESETn = 1'b1;

      // Zero-length run from IDLE: done one edge later, busy never seen.
      go("zero", 0, 7, 1'b0, 0, 0, 1'b0, 0, 0);

      // 4 x 3 add. A start pulse with a new count during RUN must be ignored.
      q10.push_back('{sum: 12, ovf: 0, cnt: 0, busy: 4});
      count_in = 5'd4;
      data_in  = 5'd3;
      mode     = 1'b0;
      start    = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      @(posedge CLOCK);
      #1;
      count_in = 5'd9;
      start    = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      drain("add4x3");

      // data_in is sampled live (1, 2, 4); a mode change in RUN has no effect.
      q10.push_back('{sum: 7, ovf: 0, cnt: 0, busy: 3});
      count_in = 5'd3;
      data_in  = 5'd1;
      mode     = 1'b0;
      start    = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      mode  = 1'b1;
      @(posedge CLOCK);
      #1;
      data_in = 5'd2;
      @(posedge CLOCK);
      #1;
      data_in = 5'd4;
      drain("live");
      mode = 1'b0;

      // Subtract underflow: 0-5-5.
      go("sub", 2, 5, 1'b1, SAT ? 0 : 1014, 1, 1'b0, 0, 0);

      // 31 x 31 add. Both instances run together; the 8-bit one overflows.
      go("add31", 31, 31, 1'b0, 961, 0, 1'b1, SAT ? 255 : 193, 1);

      // Mid-run reset after three RUN edges.
      count_in = 5'd10;
      data_in  = 5'd1;
      mode     = 1'b0;
      start    = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      repeat (3) @(posedge CLOCK);
      #1;
      chk("midrun_sum", int'(sum10), 3);
      chk("midrun_cnt", int'(cnt10), 7);
      RESETn = 1'b0;
      @(posedge CLOCK);
      #1;
      RESETn = 1'b1;
      @(negedge CLOCK);
      chk("midrst_sum", int'(sum10), 0);
      chk("midrst_busy", int'(busy10), 0);
      chk("midrst_done", int'(done10), 0);
      chk("midrst_cnt", int'(cnt10), 0);

      // Finish a run, then restart from DONE: done drops and sum restarts from 0.
      go("pre", 3, 1, 1'b0, 3, 0, 1'b0, 0, 0);
      chk("pre_done_held", int'(done10), 1);
      go("restart", 2, 4, 1'b0, 8, 0, 1'b0, 0, 0);

      repeat (2) @(negedge CLOCK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
